pwm_dac_multi: RTL and testbench

Multi-channel, parametrised PWM DAC core for the mixed-signal co-simulation flow. It drives `CHANNELS` PWM outputs from one shared period counter with a programmable clock prescaler. Per-channel duty values are double-buffered so that updates take effect only at a period boundary, which keeps the output glitch-free. An optional center-aligned (up/down) mode is available; each `pwm_o` bit feeds an external RC/analog filter.

---
 rtl/pwm_dac_multi.sv | 147 ++++++++++++++
 tb/tb_pwm_dac_multi.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_multi.sv
// Multi-channel PWM DAC: one prescaled period counter shared by all channels, with
// double-buffered duty registers. Define PWM_DAC_CENTER_EN to build the center-aligned mode.
module pwm_dac_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 4,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  center_i,
  input  logic                  set_we_i,
  input  logic [CH_W-1:0]       set_ch_i,
  input  logic [WIDTH-1:0]      set_i,
  output logic [CHANNELS-1:0]   pwm_o,
  output logic                  period_o
);

  localparam logic [WIDTH-1:0]      CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]      CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_W-1:0] PS_ZERO  = {PRESCALE_W{1'b0}};
  localparam logic [PRESCALE_W-1:0] PS_ONE   = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  logic [PRESCALE_W-1:0] presc_r;
  logic [WIDTH-1:0]      cnt_r;
  logic [WIDTH-1:0]      cnt_next_s;
  logic [WIDTH-1:0]      pending_r [CHANNELS];
  logic [WIDTH-1:0]      active_r  [CHANNELS];
  logic [CHANNELS-1:0]   cmp_s;
  logic                  tick_s;
  logic                  pstart_s;
  logic                  pstart_r;

  // ">=" rather than "==" so that lowering prescale_i below the count wraps at once
  assign tick_s   = (presc_r >= prescale_i);
  assign pstart_s = tick_s && (cnt_next_s == CNT_ZERO);

`ifdef PWM_DAC_CENTER_EN
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  logic mode_r;
  logic dir_r;
  logic dir_next_s;

  // Next counter value: free-running wrap, or up to MAX and back down to 0 in center mode
  always_comb begin
    cnt_next_s = cnt_r + CNT_ONE;
    dir_next_s = 1'b0;
    if (mode_r) begin
      if (!dir_r) begin
        if (cnt_r == CNT_MAX) begin
          cnt_next_s = CNT_MAX - CNT_ONE;
          dir_next_s = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
          dir_next_s = 1'b0;
        end
      end else begin
        cnt_next_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          dir_next_s = 1'b0;
        end else begin
          dir_next_s = 1'b1;
        end
      end
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
      dir_next_s = 1'b0;
    end
  end
`else
  // Next counter value: edge-aligned free-running wrap
  always_comb begin
    cnt_next_s = cnt_r + CNT_ONE;
  end
`endif

  // Per-channel compare of the shared counter against the active duty
  always_comb begin
    cmp_s = {CHANNELS{1'b0}};
    for (int c = 0; c < CHANNELS; c++) begin
      cmp_s[c] = (cnt_r < active_r[c]);
    end
  end

  // Prescaler, counter, duty shadow registers and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_r  <= PS_ZERO;
      cnt_r    <= CNT_ZERO;
      pstart_r <= 1'b0;
      pwm_o    <= {CHANNELS{1'b0}};
      period_o <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        pending_r[c] <= CNT_ZERO;
        active_r[c]  <= CNT_ZERO;
      end
`ifdef PWM_DAC_CENTER_EN
      mode_r <= 1'b0;
      dir_r  <= 1'b0;
`endif
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (set_we_i && (set_ch_i == CH_W'(c))) begin
          pending_r[c] <= set_i;
        end
      end
      if (!en_i) begin
        presc_r  <= PS_ZERO;
        cnt_r    <= CNT_ZERO;
        pstart_r <= 1'b0;
        pwm_o    <= {CHANNELS{1'b0}};
        period_o <= 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
          active_r[c] <= pending_r[c];
        end
`ifdef PWM_DAC_CENTER_EN
        mode_r <= center_i;
        dir_r  <= 1'b0;
`endif
      end else begin
        presc_r <= tick_s ? PS_ZERO : (presc_r + PS_ONE);
        if (tick_s) begin
          cnt_r <= cnt_next_s;
`ifdef PWM_DAC_CENTER_EN
          dir_r <= dir_next_s;
`endif
        end
        // pwm_o lags the counter by one clock, so period_o is delayed to line up with it
        pstart_r <= pstart_s;
        if (pstart_s) begin
          for (int c = 0; c < CHANNELS; c++) begin
            active_r[c] <= pending_r[c];
          end
`ifdef PWM_DAC_CENTER_EN
          mode_r <= center_i;
`endif
        end
        pwm_o    <= cmp_s;
        period_o <= pstart_r;
      end
    end
  end

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Self-checking bench for pwm_dac_multi (WIDTH=4, CHANNELS=5 so that out-of-range
// channel codes exist); the reference model tracks the period phase in ticks.
module tb_pwm_dac_multi;
  localparam int W = 4;
  localparam int C = 5;
  localparam int PW = 8;
  localparam int MAXV = (1 << W) - 1;
`ifdef PWM_DAC_CENTER_EN
  localparam bit CENTER_BUILT = 1'b1;
`else
  localparam bit CENTER_BUILT = 1'b0;
`endif

  logic          clk, rst, en, center, set_we, period;
  logic [PW-1:0] prescale;
  logic [2:0]    set_ch;
  logic [W-1:0]  set_v;
  logic [C-1:0]  pwm;

  int total = 0;
  int bad = 0;

  // reference model state
  int pend[C];
  int act[C];
  int sub, ph, js;
  bit m;
  logic [C-1:0] exp_pwm;
  logic exp_per;
  int hic[C];
  int pls;

  pwm_dac_multi #(.WIDTH(W), .CHANNELS(C), .PRESCALE_W(PW)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .prescale_i(prescale), .center_i(center),
    .set_we_i(set_we), .set_ch_i(set_ch), .set_i(set_v), .pwm_o(pwm), .period_o(period)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cnt_of(input int p, input bit md);
    if (md && p > MAXV) return 2 * MAXV - p;
    return p;
  endfunction

  function automatic int len_of(input bit md);
    return md ? 2 * MAXV : MAXV + 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < C; c++) begin
      pend[c] = 0;
      act[c] = 0;
    end
    sub = 0; ph = 0; js = 0; m = 1'b0;
    exp_pwm = '0; exp_per = 1'b0;
  endtask

  task automatic model_edge();
    bit tick;
    if (rst) begin
      model_reset();
    end else begin
      if (!en) begin
        exp_pwm = '0; exp_per = 1'b0;
        sub = 0; ph = 0; js = 0;
        for (int c = 0; c < C; c++) act[c] = pend[c];
      end else begin
        for (int c = 0; c < C; c++) exp_pwm[c] = (cnt_of(ph, m) < act[c]);
        exp_per = (js != 0);
        js = 0;
        tick = (sub >= int'(prescale));
        sub = tick ? 0 : sub + 1;
        if (tick) begin
          ph++;
          if (ph == len_of(m)) begin
            ph = 0;
            js = 1;
            for (int c = 0; c < C; c++) act[c] = pend[c];
            m = CENTER_BUILT ? center : 1'b0;
          end
        end
      end
      if (set_we && int'(set_ch) < C) pend[set_ch] = int'(set_v);
    end
  endtask

  task automatic check(input string tag, input int got, input int expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    total++;
    assert (pwm === exp_pwm) else begin
      bad++;
      $error("FAIL pwm_o t=%0t got=%b expected=%b", $time, pwm, exp_pwm);
    end
    total++;
    assert (period === exp_per) else begin
      bad++;
      $error("FAIL period_o t=%0t got=%b expected=%b", $time, period, exp_per);
    end
  endtask

  task automatic wait_period(input int bound, input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (period !== 1'b1 && n < bound);
    check(tag, int'(period === 1'b1), 1);
  endtask

  // counts highs per channel and period pulses over n samples, current sample first
  task automatic count_window(input int n);
    for (int c = 0; c < C; c++) hic[c] = int'(pwm[c]);
    pls = int'(period);
    for (int k = 1; k < n; k++) begin
      step();
      for (int c = 0; c < C; c++) hic[c] += int'(pwm[c]);
      pls += int'(period);
    end
  endtask

  task automatic write(input int ch, input int v);
    set_we = 1'b1; set_ch = 3'(ch); set_v = 4'(v);
    step();
    set_we = 1'b0;
  endtask

  initial begin
    int hi, n;
    int hk[30];
    rst = 1'b1; en = 1'b0; center = 1'b0; set_we = 1'b0; set_ch = 3'd0; set_v = 4'd0;
    prescale = 8'd0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();

    // edge mode, duty 5 on channel 0, prescale 0
    write(0, 5);
    step();
    en = 1'b1;
    wait_period(40, "first_period");
    count_window(16);
    check("edge_duty5_high", hic[0], 5);
    check("edge_pulses_per16", pls, 1);
    wait_period(1, "edge_period16");

    // shadow update: 3 -> 12 written mid-period
    en = 1'b0;
    write(0, 3);
    step();
    en = 1'b1;
    wait_period(40, "shadow_start");
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      hi += int'(pwm[0]);
      if (k == 6) begin set_we = 1'b1; set_ch = 3'd0; set_v = 4'd12; end
      else set_we = 1'b0;
    end
    check("shadow_old_duty", hi, 3);
    wait_period(1, "shadow_next");
    count_window(16);
    check("shadow_new_duty", hic[0], 12);

    // prescaler 2: duty 4, 0, 15
    en = 1'b0;
    prescale = 8'd2;
    write(0, 4);
    write(1, 0);
    write(2, 15);
    step();
    en = 1'b1;
    wait_period(100, "presc_start");
    count_window(48);
    check("presc_duty4", hic[0], 12);
    check("presc_duty0", hic[1], 0);
    check("presc_duty15", hic[2], 45);
    check("presc_pulses", pls, 1);
    wait_period(1, "presc_period48");

    // write on channel 1 in the shadow-load cycle, then an out-of-range write
    en = 1'b0;
    prescale = 8'd0;
    write(1, 2);
    step();
    en = 1'b1;
    n = 0;
    while (!(sub >= int'(prescale) && ph == len_of(m) - 1) && n < 40) begin
      step();
      n++;
    end
    check("align_load_cycle", int'(n < 40), 1);
    write(1, 9);
    wait_period(1, "load_cycle_pulse");
    hi = 0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      hi += int'(pwm[1]);
      if (k == 3) begin set_we = 1'b1; set_ch = 3'd6; set_v = 4'd15; end
      else set_we = 1'b0;
    end
    check("collide_old_value", hi, 2);
    wait_period(1, "collide_next");
    count_window(16);
    check("collide_new_value", hic[1], 9);
    check("oor_ch0_unchanged", hic[0], 4);
    check("oor_ch3_unchanged", hic[3], 0);
    check("oor_ch4_unchanged", hic[4], 0);

`ifdef PWM_DAC_CENTER_EN
    // center mode: duty 5 -> 9 high ticks in 30, symmetric about MAX
    en = 1'b0;
    write(0, 5);
    step();
    en = 1'b1;
    center = 1'b1;
    wait_period(40, "center_start");
    for (int k = 0; k < 30; k++) begin
      if (k > 0) step();
      hk[k] = int'(pwm[0]);
    end
    hi = 0;
    for (int k = 0; k < 30; k++) hi += hk[k];
    check("center_duty5_high", hi, 9);
    n = 0;
    for (int k = 1; k < 15; k++) n += int'(hk[k] != hk[30 - k]);
    check("center_symmetry", n, 0);
    wait_period(1, "center_period30");
    hi = 0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) step();
      hi += int'(pwm[0]);
      if (k == 10) center = 1'b0;
    end
    check("center_toggle_midperiod", hi, 9);
    wait_period(1, "center_toggle_len");
    count_window(16);
    check("edge_after_toggle", hic[0], 5);
`endif

    // asynchronous reset while pwm_o[0] is high
    n = 0;
    while (pwm[0] !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check("rst_setup_pwm_high", int'(pwm[0] === 1'b1), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_period", int'(period), 0);
    model_reset();
    repeat (3) step();
    rst = 1'b0;

    // randomized run against the model
    prescale = 8'($urandom_range(0, 3));
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 19) != 0);
      set_we = ($urandom_range(0, 3) == 0);
      set_ch = 3'($urandom_range(0, 7));
      set_v = 4'($urandom);
      if ($urandom_range(0, 99) == 0) prescale = 8'($urandom_range(0, 3));
      if (!en) center = m;
      else if ($urandom_range(0, 39) == 0) center = ~center;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
